// File: rtl/alu_cmd_issue_if.sv
// Command/response handshake bundle for alu_cmd_issue.
// master = command producer and response consumer; slave = the issue stage.
interface alu_cmd_issue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             cmd_a;
  logic [7:0]             cmd_b;
  logic [3:0]             cmd_sel;
  logic [TAG_W-1:0]       cmd_tag;
  logic [$clog2(DEPTH):0] cmd_count;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [7:0]             rsp_data;
  logic [TAG_W-1:0]       rsp_tag;
  logic [1:0]             rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, rsp_ready,
    input  cmd_ready, cmd_count, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, rsp_ready,
    output cmd_ready, cmd_count, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Issue stage for the 8-bit ALU: queues commands, screens illegal/div-by-zero ones,
// sequences the ALU and returns tagged results. Define ALU_CHK_EN to add the result checker.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  alu_cmd_issue_if.slave bus,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [3:0]     alu_sel,
  input  logic [7:0]     alu_out
`ifdef ALU_CHK_EN
  ,
  output logic           rsp_mismatch
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] SEL_ADD = 4'h0;
  localparam logic [3:0] SEL_SUB = 4'h1;
  localparam logic [3:0] SEL_MUL = 4'h2;
  localparam logic [3:0] SEL_DIV = 4'h3;
  localparam logic [3:0] SEL_NOP = 4'h4;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_DIV0    = 2'd2
  } err_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A pop in the same cycle does not open a slot for a push while full.
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr];

  assign bus.cmd_ready = !full;
  assign bus.cmd_count = count;

  // NOTE: the storage array has no reset; pointers and count decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel, tag: bus.cmd_tag};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   rsp_valid_q;
  logic   slot_free;
  logic   head_illegal;
  logic   head_div0;
  logic   issue;
  logic   screen;
  logic   finish;

  assign slot_free    = !rsp_valid_q || bus.rsp_ready;
  assign head_illegal = (head.sel > SEL_DIV);
  assign head_div0    = (head.sel == SEL_DIV) && (head.b == 8'h00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    screen  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && slot_free) begin
          pop = 1'b1;
          if (head_illegal || head_div0) begin
            screen = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU inputs: opcode is only non-NOP for the single EXEC cycle.
  logic [TAG_W-1:0] saved_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_sel   <= SEL_NOP;
      saved_tag <= '0;
    end else if (issue) begin
      alu_a     <= head.a;
      alu_b     <= head.b;
      alu_sel   <= head.sel;
      saved_tag <= head.tag;
    end else if (state_q == S_EXEC) begin
      alu_sel   <= SEL_NOP;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  logic [7:0]       rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  err_t             rsp_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_tag_q   <= '0;
      rsp_err_q   <= ERR_OK;
    end else if (screen) begin
      rsp_valid_q <= 1'b1;
      rsp_tag_q   <= head.tag;
      if (head_illegal) begin
        rsp_data_q <= 8'h00;
        rsp_err_q  <= ERR_ILLEGAL;
      end else begin
        rsp_data_q <= 8'hFF;
        rsp_err_q  <= ERR_DIV0;
      end
    end else if (finish) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= alu_out;
      rsp_tag_q   <= saved_tag;
      rsp_err_q   <= ERR_OK;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_CHK_EN
  // ---------------------------------------------------------------------------
  // Result checker: recomputes the ALU result from the operands still on alu_a/alu_b.
  // ---------------------------------------------------------------------------
  logic [3:0] saved_sel;

  function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
    logic [15:0] prod;
    prod = a * b;
    unique case (sel)
      SEL_ADD: ref_result = a + b;
      SEL_SUB: ref_result = a - b;
      SEL_MUL: ref_result = prod[7:0];
      SEL_DIV: ref_result = (b == 8'h00) ? 8'hFF : a / b;
      default: ref_result = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saved_sel    <= SEL_NOP;
      rsp_mismatch <= 1'b0;
    end else begin
      if (issue)  saved_sel <= head.sel;
      if (screen) rsp_mismatch <= 1'b0;
      else if (finish) rsp_mismatch <= (alu_out != ref_result(alu_a, alu_b, saved_sel));
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_alu_sel_legal: assert property (@(posedge clock) disable iff (reset)
    (alu_sel <= SEL_DIV) || (alu_sel == SEL_NOP));

  a_no_div_zero: assert property (@(posedge clock) disable iff (reset)
    (alu_sel == SEL_DIV) |-> (alu_b != 8'h00));

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));

  a_rsp_hold: assert property (@(posedge clock) disable iff (reset)
    (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_data_q)
                                         && $stable(rsp_tag_q) && $stable(rsp_err_q)));

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: behavioural ALU, scoreboard of expected
// responses pushed on command accept and compared on response accept.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_cmd_issue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = 8'h00;
  logic       mm_obs;

`ifdef ALU_CHK_EN
  logic rsp_mismatch;
  assign mm_obs = rsp_mismatch;
`else
  assign mm_obs = 1'b0;
`endif

  alu_cmd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out)
`ifdef ALU_CHK_EN
    ,
    .rsp_mismatch (rsp_mismatch)
`endif
  );

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
    logic             mm;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  logic             force_zero = 1'b0;
  bit               hold_prev = 1'b0;
  logic [7:0]       hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic [1:0]       hold_err;

  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
    logic [15:0] prod;
    prod = a * b;
    case (sel)
      4'h0:    alu_calc = a + b;
      4'h1:    alu_calc = a - b;
      4'h2:    alu_calc = prod[7:0];
      4'h3:    alu_calc = (b == 8'h00) ? 8'hFF : a / b;
      default: alu_calc = 8'h00;
    endcase
  endfunction

  // Behavioural ALU: registered result, holds on NOP.
  always @(posedge clock) begin
    if (alu_sel != 4'h4) alu_out <= force_zero ? 8'h00 : alu_calc(alu_a, alu_b, alu_sel);
  end

  function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] sel, input logic [TAG_W-1:0] tag,
                                     input logic fz);
    exp_t e;
    e.tag = tag;
    e.mm  = 1'b0;
    if (sel > 4'h3) begin
      e.data = 8'h00;
      e.err  = 2'd1;
    end else if (sel == 4'h3 && b == 8'h00) begin
      e.data = 8'hFF;
      e.err  = 2'd2;
    end else begin
      e.err  = 2'd0;
      e.data = fz ? 8'h00 : alu_calc(a, b, sel);
      e.mm   = fz && (alu_calc(a, b, sel) != 8'h00);
    end
    return e;
  endfunction

  // One clock: sample at negedge (scoreboard push/pop, hold check), return 1 after posedge.
  task automatic step(output bit acc);
    @(negedge clock);
    acc = bus.cmd_valid && bus.cmd_ready;
    if (acc) sb.push_back(expect_of(bus.cmd_a, bus.cmd_b, bus.cmd_sel, bus.cmd_tag, force_zero));
    if (hold_prev) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== hold_data || bus.rsp_tag !== hold_tag
          || bus.rsp_err !== hold_err) begin
        failures++;
        $display("FAIL rsp_hold: got v=%b d=%h t=%h e=%0d required v=1 d=%h t=%h e=%0d",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err,
                 hold_data, hold_tag, hold_err);
      end
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: got d=%h t=%h e=%0d required no response",
                 bus.rsp_data, bus.rsp_tag, bus.rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rsp_data !== e.data || bus.rsp_tag !== e.tag || bus.rsp_err !== e.err
            || mm_obs !== e.mm) begin
          failures++;
          $display("FAIL rsp_compare: got d=%h t=%h e=%0d mm=%b required d=%h t=%h e=%0d mm=%b",
                   bus.rsp_data, bus.rsp_tag, bus.rsp_err, mm_obs, e.data, e.tag, e.err, e.mm);
        end
      end
    end
    hold_prev = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1);
    hold_data = bus.rsp_data;
    hold_tag  = bus.rsp_tag;
    hold_err  = bus.rsp_err;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [TAG_W-1:0] tag);
    bit acc = 1'b0;
    int n = 0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: accepted=0 required=1");
    end
  endtask

  task automatic drain(input string name);
    bit d;
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.rsp_valid === 1'b1); i++) step(d);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d required=0", name, sb.size());
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    checks++;
    if ({bus.cmd_ready, bus.cmd_count} !== {1'b1, CNT_W'(0)}) begin
      failures++;
      $display("FAIL %s_fifo: got ready=%b count=%0d required ready=1 count=0",
               name, bus.cmd_ready, bus.cmd_count);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {8'h00, 8'h00, 4'h4}) begin
      failures++;
      $display("FAIL %s_alu: got a=%h b=%h sel=%h required a=00 b=00 sel=4",
               name, alu_a, alu_b, alu_sel);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err, mm_obs}
        !== {1'b0, 8'h00, TAG_W'(0), 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL %s_rsp: got v=%b d=%h t=%h e=%0d mm=%b required all zero",
               name, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err, mm_obs);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_sel   = 4'h0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_reset_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_latency();
    bit d;
    bus.rsp_ready = 1'b1;
    send(8'd200, 8'd100, 4'h0, 4'd5);            // accepted at edge 0
    step(d);                                      // edge 1: EXEC
    checks++;
    if ({alu_a, alu_b, alu_sel, bus.rsp_valid} !== {8'd200, 8'd100, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL exec_drive: got a=%0d b=%0d sel=%h v=%b required a=200 b=100 sel=0 v=0",
               alu_a, alu_b, alu_sel, bus.rsp_valid);
    end
    step(d);                                      // edge 2: WAIT
    checks++;
    if ({alu_sel, bus.rsp_valid} !== {4'h4, 1'b0}) begin
      failures++;
      $display("FAIL wait_nop: got sel=%h v=%b required sel=4 v=0", alu_sel, bus.rsp_valid);
    end
    step(d);                                      // edge 3: response
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency3: got rsp_valid=%b required 1", bus.rsp_valid);
    end
    drain("latency");
  endtask

  task automatic test_order();
    bus.rsp_ready = 1'b1;
    send(8'd3, 8'd5, 4'h1, 4'd1);
    send(8'd20, 8'd13, 4'h2, 4'd2);
    drain("order");
  endtask

  task automatic test_screen();
    bit d;
    bus.rsp_ready = 1'b1;
    send(8'd9, 8'd0, 4'h3, 4'd3);
    step(d);
    checks++;
    if ({alu_sel, bus.rsp_valid} !== {4'h4, 1'b1}) begin
      failures++;
      $display("FAIL div0_screen: got sel=%h v=%b required sel=4 v=1", alu_sel, bus.rsp_valid);
    end
    send(8'd7, 8'd2, 4'h9, 4'd4);
    step(d);
    checks++;
    if ({alu_sel, bus.rsp_valid} !== {4'h4, 1'b1}) begin
      failures++;
      $display("FAIL illegal_screen: got sel=%h v=%b required sel=4 v=1", alu_sel, bus.rsp_valid);
    end
    drain("screen");
  endtask

  task automatic test_stall();
    bit acc;
    int idx = 0;
    bus.rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < DEPTH + 2; cyc++) begin
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = 8'($urandom_range(1, 255));
      bus.cmd_sel   = (idx % 3 == 2) ? 4'h5 : 4'(idx % 4);
      bus.cmd_tag   = TAG_W'(idx + 6);
      bus.cmd_valid = 1'b1;
      step(acc);
      if (acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (idx != DEPTH + 1 || bus.cmd_ready !== 1'b0 || bus.cmd_count !== CNT_W'(DEPTH)) begin
      failures++;
      $display("FAIL stall_full: got accepted=%0d ready=%b count=%0d required accepted=%0d ready=0 count=%0d",
               idx, bus.cmd_ready, bus.cmd_count, DEPTH + 1, DEPTH);
    end
    bus.rsp_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_back_to_back();
    bit acc;
    int idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 20; cyc++) begin
      if (!bus.cmd_valid) begin
        bus.cmd_a   = 8'($urandom);
        bus.cmd_b   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        bus.cmd_sel = 4'($urandom_range(0, 5));
        bus.cmd_tag = TAG_W'($urandom);
      end
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      step(acc);
      if (acc) begin
        idx++;
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    checks++;
    if (idx != 20) begin
      failures++;
      $display("FAIL b2b_accept: got accepted=%0d required 20", idx);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit found = 1'b0;
    int idx = 0;
    int seen = 0;
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      if (idx < 4) begin
        bus.cmd_a     = 8'(idx + 10);
        bus.cmd_b     = 8'(idx + 1);
        bus.cmd_sel   = 4'(idx);
        bus.cmd_tag   = TAG_W'(idx + 8);
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      step(acc);
      if (acc) idx++;
      found = (alu_sel !== 4'h4) && (bus.cmd_count === CNT_W'(2));
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reset_setup: got exec_with_2_queued=0 required 1");
    end
    #2 reset = 1'b1;
    #1 expect_reset_outputs("mid_reset");
    sb.delete();
    hold_prev = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(acc);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL post_reset_rsp: got valid_cycles=%0d required 0", seen);
    end
  endtask

`ifdef ALU_CHK_EN
  task automatic test_checker();
    bus.rsp_ready = 1'b1;
    force_zero = 1'b1;
    send(8'd1, 8'd1, 4'h0, 4'd12);
    drain("chk_forced");
    force_zero = 1'b0;
    send(8'd1, 8'd1, 4'h0, 4'd13);
    drain("chk_clean");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_order();
    test_screen();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_CHK_EN
    test_checker();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
